// File: rtl/apb_copy_master.sv
// apb_copy_master: takes copy requests (length/source/destination) and moves
// each word with one APB read from source+i and one APB write to
// destination+i. Addresses wrap modulo 256.
// Optional build macro APB_TIMEOUT_EN: abandon an access after TIMEOUT
// consecutive cycles without pready and report err with done.
module apb_copy_master #(
  parameter int DATA_W   = 32,
  parameter int ADDR_INC = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              valid,
  output logic              ready,
  input  logic [3:0]        length,
  input  logic [7:0]        source,
  input  logic [7:0]        destination,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [7:0]        paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_SETUP  = 3'd1;
  localparam logic [2:0] RD_ACCESS = 3'd2;
  localparam logic [2:0] WR_SETUP  = 3'd3;
  localparam logic [2:0] WR_ACCESS = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [7:0] INC = 8'(ADDR_INC);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [3:0]        len_q;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_inc;
  logic [7:0]        src_q;
  logic [7:0]        dst_q;
  logic [7:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              in_access;
  logic              timeout;

  assign cnt_inc   = cnt_q + 4'd1;
  assign in_access = (state_q == RD_ACCESS) || (state_q == WR_ACCESS);

`ifdef APB_TIMEOUT_EN
  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wcnt_q;

  // Wait-state counter: restarts at every setup phase, counts stalled access cycles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcnt_q <= '0;
    end else if ((state_q == RD_SETUP) || (state_q == WR_SETUP)) begin
      wcnt_q <= '0;
    end else if (in_access && !pready) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  assign timeout = in_access && !pready && (wcnt_q == WCW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic for the read/write copy sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (valid) state_d = (length != 4'd0) ? RD_SETUP : DONE;
      RD_SETUP:  state_d = RD_ACCESS;
      RD_ACCESS: begin
        if (pready)       state_d = pslverr ? DONE : WR_SETUP;
        else if (timeout) state_d = DONE;
      end
      WR_SETUP:  state_d = WR_ACCESS;
      WR_ACCESS: begin
        if (pready)       state_d = (pslverr || (cnt_inc == len_q)) ? DONE : RD_SETUP;
        else if (timeout) state_d = DONE;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State, request latches, pointers, read data and error flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid) begin
            len_q <= length;
            src_q <= source;
            dst_q <= destination;
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        RD_ACCESS: begin
          if (pready) begin
            data_q <= prdata;
            if (pslverr) err_q <= 1'b1;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        WR_ACCESS: begin
          if (pready) begin
            if (pslverr) begin
              err_q <= 1'b1;
            end else begin
              src_q <= src_q + INC;
              dst_q <= dst_q + INC;
              cnt_q <= cnt_inc;
            end
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
      // paddr only moves when a setup phase begins; it holds otherwise
      if (state_d == RD_SETUP)
        addr_q <= (state_q == IDLE) ? source : (src_q + INC);
      else if (state_d == WR_SETUP)
        addr_q <= dst_q;
    end
  end

  assign ready   = (state_q == IDLE);
  assign psel    = (state_q == RD_SETUP) || (state_q == RD_ACCESS) ||
                   (state_q == WR_SETUP) || (state_q == WR_ACCESS);
  assign penable = in_access;
  assign pwrite  = (state_q == WR_SETUP) || (state_q == WR_ACCESS);
  assign paddr   = addr_q;
  assign pwdata  = data_q;
  assign done    = (state_q == DONE);
  assign err     = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_apb_copy_master.sv
// Bench for apb_copy_master: directed requests against a small APB slave
// model; expected transfers and done events go into a queue and a negedge
// monitor pops and compares them as the DUT produces them.
module tb_apb_copy_master;

  localparam logic [8:0] NONE = 9'h100;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid;
  logic        ready;
  logic [3:0]  length;
  logic [7:0]  source;
  logic [7:0]  destination;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        done;
  logic        err;

  apb_copy_master #(.DATA_W(32), .ADDR_INC(1), .TIMEOUT(15)) dut (
    .clk(clk), .nrst(nrst), .valid(valid), .ready(ready), .length(length),
    .source(source), .destination(destination), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // slave model: fixed read pattern, programmable wait states and error address
  function automatic logic [31:0] rom(input logic [7:0] a);
    return {8'hA5, a, ~a, a};
  endfunction

  int         nwait = 0;
  logic       stall = 1'b0;
  logic [8:0] err_addr = NONE;
  logic [7:0] swc = '0;

  always @(posedge clk) begin
    if (psel && penable && !pready) swc <= swc + 8'd1;
    else                            swc <= 8'd0;
  end

  assign pready  = psel && penable && !stall && (swc == 8'(nwait));
  assign pslverr = pready && !pwrite && ({1'b0, paddr} == err_addr);
  assign prdata  = rom(paddr);

  // scoreboard: kind 0 = read, 1 = write, 2 = done
  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } ev_t;

  ev_t q[$];

  int          setup_cyc = 0;
  logic [7:0]  s_addr = '0;
  logic        s_wr = 1'b0;
  logic [31:0] s_wd = '0;

  always @(negedge clk) begin
    ev_t e;
    if (nrst === 1'b1) begin
      if (psel && !penable) begin
        setup_cyc = cyc;
        s_addr = paddr;
        s_wr = pwrite;
        s_wd = pwdata;
        if (q.size() == 0 || q[0].kind == 2) chk("apb_unexpected", {31'b0, psel}, 32'd0);
        else chk("apb_dir", {31'b0, pwrite}, q[0].kind);
      end
      if (psel && penable) begin
        chk("stable_addr", paddr, s_addr);
        chk("stable_wr", {31'b0, pwrite}, {31'b0, s_wr});
        if (s_wr) chk("stable_wdata", pwdata, s_wd);
        if (pready) begin
          if (q.size() == 0) begin
            chk("xfer_unexpected", {31'b0, pready}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("xfer_kind", {31'b0, pwrite}, (e.kind == 1) ? 32'd1 : 32'd0);
            chk("xfer_addr", paddr, e.addr);
            if (pwrite) chk("wr_data", pwdata, e.data);
            else        chk("rd_setup_cyc", setup_cyc, e.cyc);
          end
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", {31'b0, done}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_order", 32'd2, e.kind);
          chk("done_err", {31'b0, err}, {31'b0, e.err});
          chk("done_cyc", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push_req(input int acc, input int len, input logic [7:0] src,
                          input logic [7:0] dst, input int w, input logic to);
    int full = 0;
    logic aborted = 1'b0;
    logic [7:0] a;
    ev_t e;
    if (to) begin
      e = '{kind: 2, addr: 8'h0, data: 32'h0, err: 1'b1, cyc: acc + 2 + 15};
      q.push_back(e);
      return;
    end
    for (int i = 0; i < len; i++) begin
      a = src + 8'(i);
      e = '{kind: 0, addr: a, data: rom(a), err: 1'b0, cyc: acc + 1 + (4 + 2 * w) * i};
      q.push_back(e);
      if ({1'b0, a} == err_addr) begin
        aborted = 1'b1;
        break;
      end
      e = '{kind: 1, addr: dst + 8'(i), data: rom(a), err: 1'b0, cyc: -1};
      q.push_back(e);
      full++;
    end
    e = '{kind: 2, addr: 8'h0, data: 32'h0, err: aborted,
          cyc: acc + 1 + (4 + 2 * w) * full + (aborted ? 2 + w : 0)};
    q.push_back(e);
  endtask

  task automatic run(input int len, input logic [7:0] src, input logic [7:0] dst,
                     input int w, input logic [8:0] ea, input logic to);
    int acc;
    int n;
    nwait = w;
    err_addr = ea;
    stall = to;
    @(negedge clk);
    acc = cyc;
    push_req(acc, len, src, dst, w, to);
    chk("ready_idle", {31'b0, ready}, 32'd1);
    valid = 1'b1;
    length = 4'(len);
    source = src;
    destination = dst;
    @(negedge clk);
    valid = 1'b0;
    length = 4'hF;
    source = 8'hAA;
    destination = 8'h55;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("done_wait", 32'd0, 32'd1);
    chk("ready_busy", {31'b0, ready}, 32'd0);
    @(negedge clk);
    chk("ready_back", {31'b0, ready}, 32'd1);
    stall = 1'b0;
    if (q.size() != 0) chk("queue_left", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    ev_t e;
    nrst = 1'b0;
    valid = 1'b0;
    length = '0;
    source = '0;
    destination = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_paddr", {24'b0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    run(3, 8'h10, 8'h40, 0, NONE, 1'b0);   // basic copy, done at cycle 13
    run(0, 8'h33, 8'h44, 0, NONE, 1'b0);   // empty request, done at cycle 1
    run(3, 8'hFE, 8'hFF, 0, NONE, 1'b0);   // address wrap
    run(4, 8'h20, 8'h60, 0, 9'h021, 1'b0); // error on second read
    run(2, 8'h30, 8'h70, 2, NONE, 1'b0);   // two wait states, done at cycle 17

    // reset while a write access is stalled
    nwait = 3;
    err_addr = NONE;
    @(negedge clk);
    acc = cyc;
    e = '{kind: 0, addr: 8'h90, data: rom(8'h90), err: 1'b0, cyc: acc + 1};
    q.push_back(e);
    e = '{kind: 1, addr: 8'hA0, data: rom(8'h90), err: 1'b0, cyc: -1};
    q.push_back(e);
    valid = 1'b1;
    length = 4'd2;
    source = 8'h90;
    destination = 8'hA0;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (!(psel && penable && pwrite) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wr_access_wait", 32'd0, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_psel", {31'b0, psel}, 32'd0);
    chk("arst_penable", {31'b0, penable}, 32'd0);
    chk("arst_ready", {31'b0, ready}, 32'd1);
    chk("arst_done", {31'b0, done}, 32'd0);
    q.delete();
    @(negedge clk);
    chk("arst_hold_done", {31'b0, done}, 32'd0);
    #2;
    nrst = 1'b1;
    run(2, 8'h50, 8'h80, 1, NONE, 1'b0);   // normal after reset

`ifdef APB_TIMEOUT_EN
    run(1, 8'h05, 8'h06, 0, NONE, 1'b1);   // pready never rises
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_copy_master.md
Name: apb_copy_master

Overview:
- Consumes copy requests from the master request interface (valid/ready, length, source, destination) and drives them onto the APB bus as an APB master.
- Per request: `length` words are copied. Each word is one APB read at source+i followed by one APB write at destination+i.
- Sits directly downstream of the request driver and upstream of the APB slave fabric in the apb_v2 subsystem.

Parameters:
- DATA_W, 32, APB data width (prdata/pwdata).
- ADDR_INC, 1, address step per word; added modulo 256 to source/destination.
- TIMEOUT, 15, max pready wait cycles per access (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- valid  input  1  request valid.
- ready  output  1  request accepted when valid && ready.
- length  input  4  number of words to copy, 0..15.
- source  input  8  first read address.
- destination  input  8  first write address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  1 = write, 0 = read.
- paddr  output  8  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  APB slave ready.
- pslverr  input  1  APB slave error, sampled with pready.
- done  output  1  one-cycle pulse at request completion.
- err  output  1  valid with done: request aborted on error.

Behaviour:
- Reset (nrst low, asynchronous): state IDLE; ready=1; psel=penable=pwrite=0; paddr=0; pwdata=0; done=err=0; internal counters cleared.
- Reset asserted mid-request abandons the transfer immediately. APB outputs drop asynchronously; no done pulse.
- States and transitions:
  - IDLE: ready=1. On valid && ready, latch length/source/destination, clear word count, clear error flag. Go to RD_SETUP if length!=0, else DONE.
  - RD_SETUP: psel=1, penable=0, pwrite=0, paddr=src_ptr. Go to RD_ACCESS.
  - RD_ACCESS: psel=1, penable=1, address/control held stable.
    - On pready: capture prdata into the data register.
    - pslverr=1 sets the error flag and goes to DONE; otherwise go to WR_SETUP.
  - WR_SETUP: psel=1, penable=0, pwrite=1, paddr=dst_ptr, pwdata=data register. Go to WR_ACCESS.
  - WR_ACCESS: psel=1, penable=1, held stable until pready.
    - On pready with pslverr=1: set the error flag and go to DONE.
    - On pready otherwise: src_ptr += ADDR_INC, dst_ptr += ADDR_INC (8-bit wrap, e.g. 0xFF+1 = 0x00), count += 1. If count reaches length go to DONE, else go to RD_SETUP.
  - DONE: done=1 for exactly one cycle, err=error flag. psel=penable=0. Go to IDLE.
- ready=0 in every state except IDLE. Request inputs are ignored outside the accept cycle.
- psel/penable are 0 in IDLE and DONE; no idle cycle is inserted between consecutive APB transfers.
- Latency with zero-wait slaves (accept at cycle 0):
  - word i read setup occurs at cycle 1+4i;
  - done occurs at cycle 4*length+1;
  - length=0 gives done at cycle 1;
  - ready returns at cycle 4*length+2.
- Each pready wait state extends the access phase by one cycle.
- pwdata holds its last value outside writes. paddr holds its last value when psel=0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: a wait counter runs in RD_ACCESS/WR_ACCESS, cleared on entering each access phase. If pready stays low for TIMEOUT consecutive access cycles, the transfer is abandoned: error flag set, state goes to DONE (psel dropped), and err=1 with done.
- Not defined: no counter; the master waits indefinitely on pready.

Test Plan:
- Reset then length=3, src=0x10, dst=0x40, zero-wait slave with memory 0x10..0x12 = A,B,C -> reads 0x10,0x11,0x12; writes 0x40=A, 0x41=B, 0x42=C; done at cycle 13, err=0.
- length=0 -> no psel activity; done at cycle 1, err=0; ready high again at cycle 2.
- src=0xFE, dst=0xFF, length=3 -> read addresses FE,FF,00; write addresses FF,00,01 (8-bit wrap).
- pslverr=1 on the second read of a length=4 request -> exactly one write performed; done with err=1; no further APB accesses.
- Slave inserts 2 wait states on every access, length=2 -> paddr/pwrite/pwdata stable throughout each access; done at cycle 17.
- nrst pulsed low during WR_ACCESS -> psel/penable/ready immediately at reset values; no done; next request completes normally. With APB_TIMEOUT_EN and TIMEOUT=15, pready held low -> done with err=1 after 15 access cycles.
